// File: rtl/bwt_pkg.sv
// rtl/bwt_pkg.sv - shared BWT pipeline constants and loader state encoding
// Purpose: terminator character, default string RAM geometry (shared with the
// length stage) and the string loader FSM state type.
package bwt_pkg;

  localparam logic [7:0] BWT_TERM_CHAR   = 8'd36;
  localparam int         BWT_LEN_ADDR    = 10;
  localparam int         BWT_LEN_STR_MAX = 1024;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_TERM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/bwt_string_loader.sv
// rtl/bwt_string_loader.sv - BWT front-end: streams a string into RAM and appends '$'
// Purpose: accepts bytes over a valid/ready handshake, writes them to the
// shared string RAM from address 0, appends the terminator and then raises CS
// for the downstream length stage.
// Optional feature: define BWT_DOLLAR_CHECK_EN to reject payload bytes equal
// to the terminator (the byte is dropped and the load aborts to ERR).
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      single-cycle load request (honoured in IDLE, DONE, ERR)
//   din        input byte; din_valid qualifies it, din_last marks final byte
//   din_ready  loader accepts a byte this cycle
//   wr_addr    RAM write address; wr_data write byte; wen write strobe
//   CS         enables the downstream length stage (string complete)
//   pay_len    payload length, terminator excluded, valid while CS
//   busy       load in progress; err load aborted
module bwt_string_loader
  import bwt_pkg::*;
#(
  parameter int len_addr    = BWT_LEN_ADDR,
  parameter int len_str_max = BWT_LEN_STR_MAX
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          din,
  input  logic                din_valid,
  input  logic                din_last,
  output logic                din_ready,
  output logic [len_addr-1:0] wr_addr,
  output logic [7:0]          wr_data,
  output logic                wen,
  output logic                CS,
  output logic [len_addr-1:0] pay_len,
  output logic                busy,
  output logic                err
);

  // Highest address a payload byte may occupy; the slot after it is kept
  // free so the terminator always fits.
  localparam logic [len_addr-1:0] LAST_PAY_ADDR = len_addr'(len_str_max - 2);

  loader_state_t       state;
  loader_state_t       state_nxt;
  logic [len_addr-1:0] cnt;
  logic                term_sent;
  logic                hs;
  logic                dollar_hit;

  assign hs = din_valid && (state == ST_LOAD);

`ifdef BWT_DOLLAR_CHECK_EN
  assign dollar_hit = (din == BWT_TERM_CHAR);
`else
  assign dollar_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (hs) begin
          if (dollar_hit) begin
            state_nxt = ST_ERR;
          end else if (din_last) begin
            state_nxt = ST_TERM;
          end else if (cnt == LAST_PAY_ADDR) begin
            state_nxt = ST_ERR;
          end
        end
      end
      // TERM spans two cycles: the first issues the '$' write, the second
      // lets that write land before DONE raises CS.
      ST_TERM: begin
        if (term_sent) state_nxt = ST_DONE;
      end
      ST_DONE, ST_ERR: begin
        if (start) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    din_ready = (state == ST_LOAD);
    busy      = (state == ST_LOAD) || (state == ST_TERM);
    CS        = (state == ST_DONE);
    err       = (state == ST_ERR);
  end

  // Address counter, registered RAM write port and payload length
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      term_sent <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wen       <= 1'b0;
      pay_len   <= '0;
    end else begin
      wen <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            cnt       <= '0;
            term_sent <= 1'b0;
            pay_len   <= '0;
          end
        end
        ST_LOAD: begin
          if (hs && !dollar_hit) begin
            wr_addr <= cnt;
            wr_data <= din;
            wen     <= 1'b1;
            cnt     <= cnt + 1'b1;
          end
        end
        ST_TERM: begin
          if (!term_sent) begin
            wr_addr   <= cnt;
            wr_data   <= BWT_TERM_CHAR;
            wen       <= 1'b1;
            term_sent <= 1'b1;
          end else begin
            pay_len <= cnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bwt_string_loader.md
# bwt_string_loader

Front-end of the BWT pipeline, directly upstream of the terminator-scanning length stage. Accepts an input byte stream over a valid/ready handshake, writes it into the shared string RAM from address 0, and appends the `$` terminator (8'd36). Raises `CS` so the length stage can scan the stored string. Reports the payload length, and flags overflow and embedded-terminator errors.

## Interface
- `len_addr`, default 10: RAM address width.
- `len_str_max`, default 1024: RAM depth in bytes, terminator included.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a new load; honoured in IDLE, DONE, ERR.
- `din`  in  8  input byte.
- `din_valid`  in  1  `din` valid.
- `din_last`  in  1  final payload byte; qualified by `din_valid`.
- `din_ready`  out  1  loader accepts a byte this cycle.
- `wr_addr`  out  len_addr  RAM write address.
- `wr_data`  out  8  RAM write data.
- `wen`  out  1  RAM write strobe, one cycle per byte.
- `CS`  out  1  enables the downstream length stage.
- `pay_len`  out  len_addr  payload bytes stored, terminator excluded.
- `busy`  out  1  load in progress.
- `err`  out  1  load aborted.

## Operation
- States:
  - IDLE: `start` -> LOAD; clears the address counter.
  - LOAD: `din_ready`=1; each handshake (`din_valid`&&`din_ready`) writes `din` at the counter address, then increments the counter.
  - `din_last` on a handshake -> TERM.
  - TERM: writes 8'd36 at the next address -> DONE.
  - DONE: `CS`=1, `pay_len` valid and held.
  - ERR: `err`=1, `CS`=0.
  - DONE and ERR: `start` -> LOAD, clearing `err`, `CS`, `pay_len` and the counter.
- Capacity: at most `len_str_max`-1 payload bytes.
- Overflow: a handshake at address `len_str_max`-2 without `din_last` writes that byte, then -> ERR. The terminator must always fit.
- Zero-length strings are not representable; every load carries at least one byte.
- `start` in LOAD or TERM is ignored.
- `busy` = LOAD or TERM.
- Counter arithmetic is unsigned, `len_addr` bits. It never wraps, because the overflow rule stops it first.

## Timing
- Reset values: `din_ready`=0, `wr_addr`=0, `wr_data`=0, `wen`=0, `CS`=0, `pay_len`=0, `busy`=0, `err`=0; state IDLE.
- `din_ready` is decoded from state (Moore) and is 1 from the first cycle after `start` is sampled.
- Write latency: a byte handshaken at edge N appears on `wr_addr`/`wr_data` with `wen`=1 in the cycle after edge N (registered).
- Terminator write: `wen` for `$` is asserted in the cycle after the final payload write.
- `CS`, `pay_len` and DONE are registered together one cycle after the terminator write. `CS` therefore never precedes a completed RAM write.
- Back-to-back handshakes are supported at one byte per cycle. Gaps in `din_valid` stall without side effects.
- A reset assertion mid-load aborts immediately to the reset values. RAM contents are left undefined.

## Configuration
- `BWT_DOLLAR_CHECK_EN` defined:
  - A handshaken byte equal to 8'd36 is not written.
  - The loader goes to ERR on the next cycle.
- `BWT_DOLLAR_CHECK_EN` undefined:
  - 8'd36 payload bytes are stored verbatim.
  - The downstream length stage then terminates at the first such byte. This is the caller's responsibility.

## Structure
- Shared package `bwt_pkg`:
  - `BWT_TERM_CHAR` = 8'd36.
  - Loader state enum (IDLE, LOAD, TERM, DONE, ERR).
  - Default `len_addr`/`len_str_max` constants, shared with the length stage.
- Single flat module; no sub-module is natural. The counter and FSM are tightly coupled.

## Test plan
- Basic load: `start`, stream "abc" with `din_last` on `c` -> writes a@0, b@1, c@2, `$`@3 on consecutive cycles; `pay_len`=3 and `CS`=1 one cycle after the `$` write.
- Backpressure gaps: same string with `din_valid` low every other cycle -> identical RAM image and `pay_len`=3, with no spurious `wen`.
- Overflow with `len_str_max`=8:
  - 7 bytes, `din_last` on the 7th -> `$`@7, `pay_len`=7.
  - 7 bytes, no `din_last` -> `err`=1 after the write at address 6; `CS` stays 0.
- Embedded terminator with `BWT_DOLLAR_CHECK_EN`: stream "a$b" -> `a`@0 written, then ERR, no `$` write.
- Embedded terminator without the macro: stream "a$b" -> all three bytes stored, plus `$`@3.
- Reset mid-load: assert `reset` low after 2 bytes -> all outputs at reset values next edge. A fresh `start` plus "xy" -> `pay_len`=2 and `$`@2.
